mainfsm: RTL and testbench

Multicycle main controller FSM for the RISC-V core. It sequences the shared datapath through fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal. It emits ALUOp to the ALU decoder, all mux selects and write enables, and handshakes with a single shared instruction/data memory port. It sits in the controller beside the ALU decoder, replacing the single-cycle main decoder.

---
 rtl/mainfsm_pkg.sv | 57 +++++
 rtl/mainfsm_outdec.sv | 84 ++++++++
 rtl/mainfsm.sv | 78 +++++++
 tb/tb_mainfsm.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mainfsm_pkg.sv
// rtl/mainfsm_pkg.sv - opcodes, select encodings, state encoding and control word for mainfsm
package mainfsm_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// rtl/mainfsm_outdec.sv - pure combinational state to Moore control word decoder
module mainfsm_outdec
  import mainfsm_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        // IRWrite/PCUpdate here depend on MemReady and are added by the FSM block
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SRCA_RD1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
      end
      S_MEMWRITE: begin
        ctrl_o.mem_req    = 1'b1;
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_EXECUTER: begin
        ctrl_o.alu_src_a = SRCA_RD1;
        ctrl_o.alu_src_b = SRCB_RD2;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl_o.alu_src_a = SRCA_RD1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a  = SRCA_RD1;
        ctrl_o.alu_src_b  = SRCB_RD2;
        ctrl_o.alu_op     = ALUOP_SUB;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.branch     = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl_o.alu_src_a  = SRCA_OLDPC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.pc_update  = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl_o.illegal    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - multicycle RISC-V main controller: state register, next state, output gating
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       InstrDone,
  output logic       Illegal
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   fetch_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_ILLEGAL: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  mainfsm_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  assign fetch_done = (state_q == S_FETCH) && MemReady;

  // reset gates requests and write enables; the selects already show FETCH values
  assign MemReq    = ctrl.mem_req & ~reset;
  assign AdrSrc    = ctrl.adr_src;
  assign IRWrite   = fetch_done & ~reset;
  assign PCUpdate  = (ctrl.pc_update | fetch_done) & ~reset;
  assign Branch    = ctrl.branch & ~reset;
  assign RegWrite  = ctrl.reg_write & ~reset;
  assign MemWrite  = ctrl.mem_write & ~reset;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ALUOp     = ctrl.alu_op;
  assign InstrDone = (ctrl.instr_done | ((state_q == S_MEMWRITE) && MemReady)) & ~reset;
  assign Illegal   = ctrl.illegal & ~reset;

endmodule

// File: tb/tb_mainfsm.sv
// tb/tb_mainfsm.sv - table-driven bench for mainfsm with cycle-count sequences
module tb_mainfsm;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic       MemReady;
  logic       MemReq, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic       InstrDone, Illegal;

  mainfsm dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .MemReady  (MemReady),
    .MemReq    (MemReq),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCUpdate  (PCUpdate),
    .Branch    (Branch),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .InstrDone (InstrDone),
    .Illegal   (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {MemReq,AdrSrc,IRWrite,PCUpdate,Branch,RegWrite,MemWrite,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,InstrDone,Illegal}
  logic [16:0] act;
  assign act = {MemReq, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
                ALUSrcA, ALUSrcB, ResultSrc, ALUOp, InstrDone, Illegal};

  localparam logic [16:0] E_RST  = 17'b0000000_00_10_10_00_00;
  localparam logic [16:0] E_F0   = 17'b1000000_00_10_10_00_00;
  localparam logic [16:0] E_F1   = 17'b1011000_00_10_10_00_00;
  localparam logic [16:0] E_DEC  = 17'b0000000_01_01_00_00_00;
  localparam logic [16:0] E_MADR = 17'b0000000_10_01_00_00_00;
  localparam logic [16:0] E_MRD  = 17'b1100000_00_00_00_00_00;
  localparam logic [16:0] E_MWB  = 17'b0000010_00_00_01_00_10;
  localparam logic [16:0] E_MWR0 = 17'b1100001_00_00_00_00_00;
  localparam logic [16:0] E_MWR1 = 17'b1100001_00_00_00_00_10;
  localparam logic [16:0] E_EXR  = 17'b0000000_10_00_00_10_00;
  localparam logic [16:0] E_EXI  = 17'b0000000_10_01_00_10_00;
  localparam logic [16:0] E_AWB  = 17'b0000010_00_00_00_00_10;
  localparam logic [16:0] E_BEQ  = 17'b0000100_10_00_00_01_10;
  localparam logic [16:0] E_JAL  = 17'b0001000_01_10_00_00_00;
  localparam logic [16:0] E_ILL  = 17'b0000000_00_00_00_00_11;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

  typedef struct {
    logic        rst;
    logic [6:0]  opc;
    logic        rdy;
    logic [16:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  task automatic add(input logic r, input logic [6:0] o, input logic rd, input logic [16:0] e, input string t);
    vec_t v;
    v.rst = r; v.opc = o; v.rdy = rd; v.exp = e; v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic count_instr(input logic [6:0] o, input int want, input string t);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < 30) begin
      @(posedge clk);
      #1;
      reset = 1'b0; op = o; MemReady = 1'b1;
      n++;
      @(negedge clk);
      if (InstrDone) done = 1'b1;
    end
    checks++;
    if (!done || n != want) begin
      failures++;
      $display("FAIL cycles_%s got=%0d want=%0d done=%0d", t, n, want, done);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    op = 7'd0;
    MemReady = 1'b0;

    add(1, LW, 0, E_RST, "rst_rdy0");
    add(1, LW, 1, E_RST, "rst_rdy1");
    add(0, LW, 0, E_F0,  "fetch_stall");
    add(0, LW, 1, E_F1,  "lw_fetch");
    add(0, LW, 1, E_DEC, "lw_dec");
    add(0, LW, 1, E_MADR,"lw_madr");
    add(0, LW, 0, E_MRD, "lw_mrd_stall");
    add(0, LW, 1, E_MRD, "lw_mrd");
    add(0, LW, 1, E_MWB, "lw_mwb");
    add(0, SW, 1, E_F1,  "sw_fetch");
    add(0, SW, 1, E_DEC, "sw_dec");
    add(0, SW, 1, E_MADR,"sw_madr");
    add(0, SW, 0, E_MWR0,"sw_mwr_s1");
    add(0, SW, 0, E_MWR0,"sw_mwr_s2");
    add(0, SW, 0, E_MWR0,"sw_mwr_s3");
    add(0, SW, 1, E_MWR1,"sw_mwr_done");
    add(0, RT, 1, E_F1,  "r_fetch");
    add(0, RT, 1, E_DEC, "r_dec");
    add(0, RT, 1, E_EXR, "r_exe");
    add(0, RT, 1, E_AWB, "r_wb");
    add(0, BQ, 1, E_F1,  "beq_fetch");
    add(0, BQ, 1, E_DEC, "beq_dec");
    add(0, BQ, 1, E_BEQ, "beq_beq");
    add(0, JL, 1, E_F1,  "jal_fetch");
    add(0, JL, 1, E_DEC, "jal_dec");
    add(0, JL, 1, E_JAL, "jal_jal");
    add(0, JL, 1, E_AWB, "jal_wb");
    add(0, IT, 1, E_F1,  "i_fetch");
    add(0, IT, 1, E_DEC, "i_dec");
    add(0, IT, 1, E_EXI, "i_exe");
    add(0, IT, 1, E_AWB, "i_wb");
    add(0, BAD, 1, E_F1, "ill_fetch");
    add(0, BAD, 1, E_DEC,"ill_dec");
    add(0, BAD, 1, E_ILL,"ill_ill");
    add(0, SW, 1, E_F1,  "sw2_fetch");
    add(0, SW, 1, E_DEC, "sw2_dec");
    add(0, SW, 1, E_MADR,"sw2_madr");
    add(0, SW, 0, E_MWR0,"sw2_mwr");
    add(1, SW, 0, E_RST, "sw2_reset_mid");
    add(0, SW, 0, E_F0,  "post_rst_fetch");
    add(0, RT, 1, E_F1,  "r2_fetch");
    add(0, RT, 1, E_DEC, "r2_dec");
    add(0, RT, 1, E_EXR, "r2_exe");
    add(0, RT, 1, E_AWB, "r2_wb");

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      reset = vecs[i].rst;
      op = vecs[i].opc;
      MemReady = vecs[i].rdy;
      @(negedge clk);
      checks++;
      if (act !== vecs[i].exp) begin
        failures++;
        $display("FAIL vec%0d_%s got=%b want=%b", i, vecs[i].tag, act, vecs[i].exp);
      end
    end

    count_instr(LW, 5, "lw");
    count_instr(SW, 4, "sw");
    count_instr(RT, 4, "rtype");
    count_instr(BQ, 3, "beq");
    count_instr(IT, 4, "itype");
    count_instr(JL, 4, "jal");
    count_instr(BAD, 3, "illegal");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
